// File: rtl/ft64_bmm_pkg.sv
// ft64_bmm_pkg: shared op encodings, FSM states, matrix index maximum and op legality for the 8x8 bit-matrix unit (transpose legal only with FT64_BMM_MTRANS_EN)
package ft64_bmm_pkg;
  localparam int BMM_N = 7;
  typedef enum logic [1:0] {OP_MOR = 2'b00, OP_MXOR = 2'b01, OP_MTRANS = 2'b10, OP_RSVD = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  function automatic logic op_legal(input logic [1:0] op);
`ifdef FT64_BMM_MTRANS_EN
    return op != OP_RSVD;
`else
    return op == OP_MOR || op == OP_MXOR;
`endif
  endfunction
endpackage

// File: rtl/ft64_bmm_row.sv
// ft64_bmm_row: one result row; i_row = row r of A, i_b = all of B (A itself for transpose), i_r = row index, i_op = op, o_row = row r of the result (0 for illegal ops)
module ft64_bmm_row
  import ft64_bmm_pkg::*;
(
  input  logic [7:0]  i_row,
  input  logic [63:0] i_b,
  input  logic [2:0]  i_r,
  input  logic [1:0]  i_op,
  output logic [7:0]  o_row
);
  logic [7:0] w_or, w_xor;
  always_comb begin
    w_or = '0;
    w_xor = '0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 8; k++) begin
        w_or[7-j] = w_or[7-j] | (i_row[7-k] & i_b[{3'(7 - k), 3'(7 - j)}]);
        w_xor[7-j] = w_xor[7-j] ^ (i_row[7-k] & i_b[{3'(7 - k), 3'(7 - j)}]);
      end
  end
`ifdef FT64_BMM_MTRANS_EN
  logic [7:0] w_tr;
  always_comb begin
    w_tr = '0;
    for (int j = 0; j < 8; j++)
      w_tr[7-j] = i_b[{3'(7 - j), ~i_r}];
  end
  assign o_row = i_op == OP_MOR ? w_or : i_op == OP_MXOR ? w_xor : i_op == OP_MTRANS ? w_tr : 8'h00;
`else
  logic w_unused;
  assign w_unused = ^i_r;
  assign o_row = i_op == OP_MOR ? w_or : i_op == OP_MXOR ? w_xor : 8'h00;
`endif
endmodule

// File: rtl/ft64_bmm_iter.sv
// ft64_bmm_iter: iterative 8x8 bit-matrix MOR/MXOR/MTRANS, one row per clock, 8-clock latency; ports clk/rst/clear, ld/op/a/b/id in, idle, o_valid/o_ready/o/o_id/exc out; FT64_BMM_MTRANS_EN enables transpose
module ft64_bmm_iter
  import ft64_bmm_pkg::*;
#(
  parameter int DBW = 64,
  parameter int N = BMM_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           ld,
  input  logic [1:0]     op,
  input  logic [DBW-1:0] a,
  input  logic [DBW-1:0] b,
  input  logic [4:0]     id,
  output logic           idle,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [DBW-1:0] o,
  output logic [4:0]     o_id,
  output logic           exc
);
  state_e r_state, w_nxt;
  logic [2:0] r_cnt;
  logic [DBW-1:0] r_a, r_b, r_o;
  logic [1:0] r_op;
  logic [4:0] r_id;
  logic r_exc, w_acc;
  logic [7:0] w_row;
  assign idle = r_state == ST_IDLE || (r_state == ST_DONE && o_ready);
  assign w_acc = ld && idle && !clear;
  assign o_valid = r_state == ST_DONE;
  assign o = r_o;
  assign o_id = r_id;
  assign exc = r_exc;
  always_comb begin
    w_nxt = clear ? ST_IDLE :
            w_acc ? ST_RUN :
            (r_state == ST_RUN && r_cnt == 3'(N)) ? ST_DONE :
            (r_state == ST_DONE && o_ready) ? ST_IDLE : r_state;
  end
  always_ff @(posedge clk) r_state <= rst ? ST_IDLE : w_nxt;
  ft64_bmm_row u_row (
    .i_row(r_a[{~r_cnt, 3'b000} +: 8]),
    .i_b  (r_b),
    .i_r  (r_cnt),
    .i_op (r_op),
    .o_row(w_row)
  );
  // Transpose reads columns of A through the B path, so A is latched there too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_o <= '0;
      r_op <= OP_MOR;
      r_id <= '0;
      r_exc <= 1'b0;
    end else if (clear) r_cnt <= '0;
    else if (w_acc) begin
      r_cnt <= '0;
      r_a <= a;
      r_b <= op == OP_MTRANS ? a : b;
      r_o <= '0;
      r_op <= op;
      r_id <= id;
      r_exc <= !op_legal(op);
    end else if (r_state == ST_RUN) begin
      r_o[{~r_cnt, 3'b000} +: 8] <= w_row;
      r_cnt <= r_cnt + 3'd1;
    end
  end
endmodule

// File: tb/tb_ft64_bmm_iter.sv
// tb_ft64_bmm_iter: randomized self-checking bench for ft64_bmm_iter against a matrix-arithmetic reference model
module tb_ft64_bmm_iter;
  logic clk = 0, rst = 1, clear = 0, ld = 0, o_ready = 0;
  logic [1:0] op = 0;
  logic [63:0] a = 0, b = 0;
  logic [4:0] id = 0;
  logic idle, o_valid, exc;
  logic [63:0] o;
  logic [4:0] o_id;
  int total = 0, bad = 0;
`ifdef FT64_BMM_MTRANS_EN
  localparam bit MT = 1;
`else
  localparam bit MT = 0;
`endif
  ft64_bmm_iter dut (
    .clk(clk), .rst(rst), .clear(clear), .ld(ld), .op(op), .a(a), .b(b), .id(id),
    .idle(idle), .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_id(o_id), .exc(exc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit el(input logic [63:0] m, input int i, input int j);
    return m[(7 - i) * 8 + (7 - j)];
  endfunction
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [63:0] ma, input logic [63:0] mb);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        int s = 0;
        bit v;
        for (int k = 0; k < 8; k++) s += el(ma, i, k) * el(mb, k, j);
        v = mop == 2'b00 ? s > 0 : mop == 2'b01 ? s % 2 == 1 : (mop == 2'b10 && MT) ? el(ma, j, i) : 1'b0;
        r[(7 - i) * 8 + (7 - j)] = v;
      end
    return r;
  endfunction
  function automatic bit model_exc(input logic [1:0] mop);
    return mop == 2'b11 || (mop == 2'b10 && !MT);
  endfunction
  task automatic start(input logic [1:0] sop, input logic [63:0] sa, input logic [63:0] sb, input logic [4:0] sid);
    op = sop; a = sa; b = sb; id = sid; ld = 1;
    @(posedge clk); #1;
    ld = 0; o_ready = 0;
  endtask
  task automatic wait_res(input logic [1:0] sop, input logic [63:0] sa, input logic [63:0] sb, input logic [4:0] sid);
    logic [63:0] e = model(sop, sa, sb);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 4) chk("partial_rows", o, {e[63:32], 32'h0});
      if (n == 7) chk("valid_early", 64'(o_valid), 64'd0);
      if (n == 8) begin
        chk("valid_lat8", 64'(o_valid), 64'd1);
        chk("o", o, e);
        chk("o_id", 64'(o_id), 64'(sid));
        chk("exc", 64'(exc), 64'(model_exc(sop)));
      end
    end
  endtask
  task automatic run(input logic [1:0] sop, input logic [63:0] sa, input logic [63:0] sb, input logic [4:0] sid);
    chk("idle_before", 64'(idle), 64'd1);
    start(sop, sa, sb, sid);
    wait_res(sop, sa, sb, sid);
    o_ready = 1;
    @(posedge clk); #1;
    o_ready = 0;
    chk("valid_after_hs", 64'(o_valid), 64'd0);
  endtask
  initial begin
    logic [63:0] ho, na, nb;
    logic [4:0] hid;
    logic [1:0] nop;
    int seen;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_o", o, 64'd0);
    chk("rst_id", 64'(o_id), 64'd0);
    chk("rst_exc", 64'(exc), 64'd0);
    run(2'b00, 64'h8040201008040201, 64'h0123456789ABCDEF, 5'd3);
    chk("identity_const", o, 64'h0123456789ABCDEF);
    run(2'b00, '1, '1, 5'd4);
    run(2'b01, '1, '1, 5'd5);
    run(2'b10, 64'h00000000000000FF, $urandom, 5'd6);
    run(2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 5'd7);
    for (int t = 0; t < 24; t++)
      run(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
    na = {$urandom, $urandom}; nb = {$urandom, $urandom};
    start(2'b01, na, nb, 5'd9);
    wait_res(2'b01, na, nb, 5'd9);
    ho = o; hid = o_id;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_o", o, ho);
      chk("bp_id", 64'(o_id), 64'(hid));
    end
    o_ready = 1;
    #1 chk("b2b_idle", 64'(idle), 64'd1);
    nop = 2'($urandom_range(0, 1)); na = {$urandom, $urandom}; nb = {$urandom, $urandom};
    start(nop, na, nb, 5'd17);
    wait_res(nop, na, nb, 5'd17);
    o_ready = 1;
    @(posedge clk); #1;
    o_ready = 0;
    start(2'b00, {$urandom, $urandom}, {$urandom, $urandom}, 5'd21);
    repeat (3) @(posedge clk);
    #1 clear = 1; ld = 1;
    @(posedge clk); #1;
    clear = 0; ld = 0;
    chk("clr_idle", 64'(idle), 64'd1);
    chk("clr_valid", 64'(o_valid), 64'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    chk("clr_no_result", 64'(seen), 64'd0);
    na = {$urandom, $urandom}; nb = {$urandom, $urandom};
    start(2'b00, na, nb, 5'd30);
    wait_res(2'b00, na, nb, 5'd30);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_done_valid", 64'(o_valid), 64'd0);
    chk("rst_done_o", o, 64'd0);
    chk("rst_done_id", 64'(o_id), 64'd0);
    chk("rst_done_exc", 64'(exc), 64'd0);
    chk("rst_done_idle", 64'(idle), 64'd1);
    run(2'b01, na, nb, 5'd31);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
